rr_mux_arb: RTL and testbench
=============================

Name: rr_mux_arb

Overview:
- Parametrised N-input, WIDTH-bit arbitrated multiplexer with a registered output stage.
- Generalises the team's 2:1 dataflow mux:
  - N channels instead of two.
  - valid/ready handshakes on every input and on the output.
  - selectable round-robin or fixed-priority arbitration.
  - an XOR-reduction parity bit on the output.
- Sits between several producer streams and one shared consumer, e.g. a bus or port merge point.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
- CW, clog2(N), channel-index width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  N  per-channel data valid.
- in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered selected data.
- out_chan  output  CW  index of the channel that supplied out_data.
- out_parity  output  1  XOR of all out_data bits (even-parity bit).
- out_ready  input  1  consumer accepts the beat.

Behaviour:
- Reset (async assert, sync deassert by design):
  - out_valid=0, out_data=0, out_chan=0, out_parity=0.
  - RR pointer=0, FSM=EMPTY.
- FSM: two states, EMPTY and FULL.
  - EMPTY -> FULL when any in_valid is set.
  - FULL -> EMPTY when out_ready is set and no in_valid is set.
  - FULL stays FULL when out_ready=0, or when out_ready=1 and some in_valid is set (back-to-back transfer).
- load_en = (state==EMPTY) | out_ready.
- Grant:
  - Combinational; exactly one bit is set when any in_valid is set and load_en=1, otherwise zero.
  - in_ready = grant.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
- MODE=0 (round-robin):
  - Search starts at the pointer index and wraps modulo N.
  - After a transfer on channel g, pointer <= (g+1) mod N; g=N-1 wraps to 0.
  - Pointer holds when no transfer occurs.
- MODE=1 (fixed priority): lowest-index valid channel wins; pointer is unused and held at 0.
- On transfer:
  - out_data <= selected in_data, out_chan <= g, out_parity <= ^selected data.
  - All three update in the same edge.
- Latency: 1 cycle from input transfer to out_valid=1. Throughput is 1 beat per cycle while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data, out_chan and out_parity are held stable.
  - in_ready is all zero.
- Simultaneous drain and load in one cycle:
  - The new beat replaces the old one.
  - out_valid stays 1 with no bubble.
- in_valid changing while not granted: no effect, no state change.
- Reset mid-operation: any held beat is dropped, all outputs and the pointer return to reset values immediately.
- in_ready depends combinationally on in_valid and out_ready. It must not be fed back combinationally into in_valid by producers.

Decomposition:
- Shared package/include defines:
  - MODE_RR=0 and MODE_FIXED=1.
  - the clog2 function used for CW.
- One natural sub-module, rr_grant:
  - combinational N-bit arbiter.
  - inputs: request vector, pointer, mode.
  - outputs: one-hot grant and its encoded index.
- The output register and FSM stay in rr_mux_arb.

Test Plan (N=4, WIDTH=8 unless noted):
- Reset check: assert rst mid-run with out_valid=1 -> same cycle out_valid=0, out_data=0, out_chan=0, out_parity=0; next grant with all valid goes to channel 0.
- Single channel: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=A5, out_chan=2, out_parity=0. Repeat with 8'h07 -> out_parity=1.
- Round-robin fairness: in_valid=4'b1111 held, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 on consecutive cycles with out_valid constantly 1.
- Backpressure: beat from channel 1 loaded, then out_ready=0 for 3 cycles with in_valid=4'b1111 -> out_data/out_chan unchanged, in_ready=0; on out_ready=1 the next beat is channel 2 in the same cycle.
- Fixed priority: MODE=1, in_valid=4'b1010 held, out_ready=1 -> out_chan 1 on every beat, channel 3 starved; drop in_valid[1] -> channel 3 served.
- Parametric: N=3, WIDTH=16, in_valid=3'b111 -> out_chan 0,1,2,0 (wrap at N-1); parity matches XOR of 16 bits for 16'hFFFF (0) and 16'h8000 (1).

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg
//   Shared definitions for the arbitrated multiplexer slice:
//   - MODE_RR / MODE_FIXED : arbitration mode encodings for the MODE parameter
//   - arb_state_e          : output-register occupancy state (EMPTY / FULL)
//   - clog2()              : ceiling log2, used to size the channel index
package rr_mux_arb_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

  // Smallest r with 2**r >= n; callers guarantee n >= 2.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_mux_arb_if.sv
// rr_mux_arb_if
//   Bundles the N producer streams and the single consumer stream.
//   Handshake rule (both sides): a beat moves on a rising clk edge when
//   valid and ready are both 1 in that cycle. The multiplexer's in_ready is
//   a combinational function of in_valid and out_ready, so producers must
//   not derive in_valid from in_ready.
//   Signals:
//     in_valid   [N]        per-channel valid
//     in_data    [N*WIDTH]  channel i at bits [i*WIDTH +: WIDTH]
//     in_ready   [N]        per-channel accept, one-hot or zero
//     out_valid             output register holds a beat
//     out_data   [WIDTH]    registered data
//     out_chan   [CW]       source channel of out_data
//     out_parity            XOR of all out_data bits
//     out_ready             consumer accepts the beat
//   Modports: slave = multiplexer side, master = producers/consumer side.
interface rr_mux_arb_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  import rr_mux_arb_pkg::*;

  localparam int CW = clog2(N);

  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_chan;
  logic               out_parity;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, out_parity
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, out_parity
  );

endinterface

// File: rtl/rr_mux_arb_grant.sv
// rr_grant
//   Combinational N-way arbiter. Scans the request vector starting at the
//   pointer (round-robin) or at index 0 (fixed priority), wrapping modulo N,
//   and grants the first requester found.
//   Ports:
//     req   [N]   request vector (already qualified by the caller)
//     ptr   [CW]  round-robin start index, ignored when mode=1
//     mode        0 = round-robin, 1 = fixed priority
//     grant [N]   one-hot grant, zero when req is zero
//     idx   [CW]  encoded index of the granted bit (0 when no grant)
module rr_grant #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] ptr,
  input  logic          mode,
  output logic [N-1:0]  grant,
  output logic [CW-1:0] idx
);

  int   start;
  int   cand;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    start = mode ? 0 : int'(ptr);
    for (int k = 0; k < N; k++) begin
      // start < N and k < N, so a single subtraction performs the wrap.
      cand = start + k;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = CW'(cand);
      end
    end
  end

endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb
//   N-input arbitrated multiplexer with a one-beat registered output stage.
//   A beat is accepted from the granted channel whenever the output register
//   is empty or is being drained in the same cycle, so the stage sustains one
//   beat per cycle with no bubble while out_ready=1.
//   Ports:
//     clk        rising-edge clock
//     rst        asynchronous active-high reset
//     bus        rr_mux_arb_if.slave (streams, see interface header)
//     state_dbg  current occupancy state of the output register
module rr_mux_arb
  import rr_mux_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_RR
) (
  input  logic        clk,
  input  logic        rst,
  rr_mux_arb_if.slave bus,
  output arb_state_e  state_dbg
);

  localparam int CW = clog2(N);

  arb_state_e       state;
  arb_state_e       state_next;
  logic [CW-1:0]    ptr;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    chan_q;
  logic             parity_q;

  logic             any_valid;
  logic             load_en;
  logic [N-1:0]     req;
  logic [N-1:0]     grant;
  logic [CW-1:0]    gidx;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;

  assign any_valid = |bus.in_valid;
  // The register may take a new beat when empty or when its current beat
  // leaves this cycle.
  assign load_en   = (state == ST_EMPTY) | bus.out_ready;
  assign req       = bus.in_valid & {N{load_en}};
  assign xfer      = |grant;

  rr_grant #(
    .N  (N),
    .CW (CW)
  ) u_grant (
    .req   (req),
    .ptr   (ptr),
    .mode  (MODE == MODE_FIXED),
    .grant (grant),
    .idx   (gidx)
  );

  // One-hot AND-OR select avoids a variable part-select on the flat bus.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = sel_data | bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (any_valid) state_next = ST_FULL;
      ST_FULL:  if (bus.out_ready && !any_valid) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q   <= '0;
      chan_q   <= '0;
      parity_q <= 1'b0;
      ptr      <= '0;
    end else if (xfer) begin
      data_q   <= sel_data;
      chan_q   <= gidx;
      parity_q <= ^sel_data;
      // Fixed priority never moves the pointer, so it stays at its reset 0.
      if (MODE == MODE_RR) begin
        ptr <= (gidx == CW'(N - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign bus.in_ready   = grant;
  assign bus.out_valid  = (state == ST_FULL);
  assign bus.out_data   = data_q;
  assign bus.out_chan   = chan_q;
  assign bus.out_parity = parity_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb
//   Three instances: round-robin N=4/W=8 (a), fixed-priority N=4/W=8 (b),
//   round-robin N=3/W=16 (c). Instances a and b share stimulus and are
//   compared each cycle against a transaction-level model; c is exercised
//   with directed steps.
module tb_rr_mux_arb;
  import rr_mux_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rr_mux_arb_if #(.N(4), .WIDTH(8))  a_if ();
  rr_mux_arb_if #(.N(4), .WIDTH(8))  b_if ();
  rr_mux_arb_if #(.N(3), .WIDTH(16)) c_if ();
  arb_state_e st_a, st_b, st_c;

  rr_mux_arb #(.N(4), .WIDTH(8), .MODE(MODE_RR)) dut_a (
    .clk (clk), .rst (rst), .bus (a_if.slave), .state_dbg (st_a)
  );
  rr_mux_arb #(.N(4), .WIDTH(8), .MODE(MODE_FIXED)) dut_b (
    .clk (clk), .rst (rst), .bus (b_if.slave), .state_dbg (st_b)
  );
  rr_mux_arb #(.N(3), .WIDTH(16), .MODE(MODE_RR)) dut_c (
    .clk (clk), .rst (rst), .bus (c_if.slave), .state_dbg (st_c)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: one held beat per instance (index 0 = a, 1 = b)
  int         m_ptr[2];
  bit         m_v[2];
  logic [7:0] m_d[2];
  int         m_c[2];

  logic [3:0] ab_valid;
  logic [7:0] ab_data[4];
  logic       ab_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_v[m] = 0; m_d[m] = '0; m_c[m] = 0;
    end
  endtask

  // Winner for this cycle, or -1 when nothing can move.
  function automatic int model_pick(input int m);
    int start;
    if (m_v[m] && !ab_ready) return -1;
    start = (m == 1) ? 0 : m_ptr[m];
    for (int k = 0; k < 4; k++) begin
      if (ab_valid[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive_ab(input logic [3:0] v, input logic [31:0] d, input logic r);
    ab_valid = v;
    ab_ready = r;
    for (int i = 0; i < 4; i++) ab_data[i] = d[i*8 +: 8];
    a_if.in_valid = v; a_if.in_data = d; a_if.out_ready = r;
    b_if.in_valid = v; b_if.in_data = d; b_if.out_ready = r;
  endtask

  task automatic check_out(input string tag, input int m, input logic v, input logic [7:0] d,
                           input logic [1:0] c, input logic p, input arb_state_e s);
    chk($sformatf("%s_valid", tag), 32'(v), 32'(m_v[m]));
    chk($sformatf("%s_state", tag), 32'(s), m_v[m] ? 32'(ST_FULL) : 32'(ST_EMPTY));
    if (m_v[m]) begin
      chk($sformatf("%s_data", tag), 32'(d), 32'(m_d[m]));
      chk($sformatf("%s_chan", tag), 32'(c), 32'(m_c[m]));
      chk($sformatf("%s_parity", tag), 32'(p), 32'($countones(m_d[m]) % 2));
    end
  endtask

  // One clock: check grants before the edge, outputs just after it.
  task automatic cycle();
    int g[2];
    #1;
    for (int m = 0; m < 2; m++) g[m] = model_pick(m);
    chk("a_in_ready", 32'(a_if.in_ready), (g[0] >= 0) ? 32'(4'b1 << g[0]) : 32'd0);
    chk("b_in_ready", 32'(b_if.in_ready), (g[1] >= 0) ? 32'(4'b1 << g[1]) : 32'd0);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (g[m] >= 0) begin
        m_v[m] = 1'b1;
        m_d[m] = ab_data[g[m]];
        m_c[m] = g[m];
        if (m == 0) m_ptr[m] = (g[m] + 1) % 4;
      end else if (ab_ready) begin
        m_v[m] = 1'b0;
      end
    end
    #1;
    check_out("a", 0, a_if.out_valid, a_if.out_data, a_if.out_chan, a_if.out_parity, st_a);
    check_out("b", 1, b_if.out_valid, b_if.out_data, b_if.out_chan, b_if.out_parity, st_b);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    model_reset();
    drive_ab(4'h0, 32'h0, 1'b1);
    c_if.in_valid  = '0;
    c_if.in_data   = '0;
    c_if.out_ready = 1'b1;

    // reset state
    #1;
    chk("rst_a_valid", 32'(a_if.out_valid), 32'd0);
    chk("rst_a_data", 32'(a_if.out_data), 32'd0);
    chk("rst_c_valid", 32'(c_if.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // round-robin fairness, all channels valid
    for (int i = 0; i < 8; i++) begin
      drive_ab(4'hF, 32'h44332211, 1'b1);
      cycle();
      chk("rr_seq_chan", 32'(a_if.out_chan), 32'(i % 4));
      chk("fixed_all_chan", 32'(b_if.out_chan), 32'd0);
    end

    // single channel, parity 0 then 1
    drive_ab(4'b0100, 32'h00A50000, 1'b1);
    cycle();
    chk("single_a5_data", 32'(a_if.out_data), 32'hA5);
    chk("single_a5_chan", 32'(a_if.out_chan), 32'd2);
    chk("single_a5_parity", 32'(a_if.out_parity), 32'd0);
    drive_ab(4'b0100, 32'h00070000, 1'b1);
    cycle();
    chk("single_07_parity", 32'(a_if.out_parity), 32'd1);
    drive_ab(4'b0000, 32'h0, 1'b1);
    cycle();
    chk("drain_valid", 32'(a_if.out_valid), 32'd0);

    // backpressure: hold channel-1 beat for three cycles
    drive_ab(4'b0010, 32'h00005500, 1'b1);
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive_ab(4'hF, 32'hD4C3B2A1, 1'b0);
      cycle();
      chk("bp_hold_chan", 32'(a_if.out_chan), 32'd1);
      chk("bp_hold_data", 32'(a_if.out_data), 32'h55);
      chk("bp_in_ready", 32'(a_if.in_ready), 32'd0);
    end
    drive_ab(4'hF, 32'hD4C3B2A1, 1'b1);
    #1;
    chk("bp_release_grant", 32'(a_if.in_ready), 32'b0100);
    cycle();
    chk("bp_release_chan", 32'(a_if.out_chan), 32'd2);
    chk("bp_release_data", 32'(a_if.out_data), 32'hC3);

    // fixed priority starvation, then channel 3 served
    for (int i = 0; i < 4; i++) begin
      drive_ab(4'b1010, 32'h44332211, 1'b1);
      cycle();
      chk("fixed_starve_chan", 32'(b_if.out_chan), 32'd1);
    end
    drive_ab(4'b1000, 32'h44332211, 1'b1);
    cycle();
    chk("fixed_ch3_chan", 32'(b_if.out_chan), 32'd3);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive_ab(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0);
      cycle();
    end

    // reset while a beat is held
    drive_ab(4'hF, 32'h44332211, 1'b1);
    cycle();
    chk("pre_rst_valid", 32'(a_if.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_a_valid", 32'(a_if.out_valid), 32'd0);
    chk("mid_rst_a_data", 32'(a_if.out_data), 32'd0);
    chk("mid_rst_a_chan", 32'(a_if.out_chan), 32'd0);
    chk("mid_rst_a_parity", 32'(a_if.out_parity), 32'd0);
    chk("mid_rst_a_state", 32'(st_a), 32'(ST_EMPTY));
    chk("mid_rst_b_valid", 32'(b_if.out_valid), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive_ab(4'hF, 32'h44332211, 1'b1);
    cycle();
    chk("post_rst_chan", 32'(a_if.out_chan), 32'd0);

    // N=3, WIDTH=16: wrap at N-1 and 16-bit parity
    drive_ab(4'h0, 32'h0, 1'b1);
    c_if.in_valid = 3'b111;
    c_if.in_data  = {16'h3333, 16'h2222, 16'h1111};
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("n3_valid", 32'(c_if.out_valid), 32'd1);
      chk("n3_chan", 32'(c_if.out_chan), 32'(i % 3));
    end
    c_if.in_valid = 3'b010;
    c_if.in_data  = {16'h0000, 16'hFFFF, 16'h0000};
    #1;
    chk("n3_in_ready", 32'(c_if.in_ready), 32'b010);
    cycle();
    chk("n3_ffff_data", 32'(c_if.out_data), 32'hFFFF);
    chk("n3_ffff_parity", 32'(c_if.out_parity), 32'd0);
    c_if.in_data  = {16'h0000, 16'h8000, 16'h0000};
    cycle();
    chk("n3_8000_data", 32'(c_if.out_data), 32'h8000);
    chk("n3_8000_parity", 32'(c_if.out_parity), 32'd1);
    chk("n3_8000_chan", 32'(c_if.out_chan), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
